sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL provide parameter: WIDTH, 8, bits per deserialized word.
REQ-002 SHALL provide parameter: DEPTH, 2, number of completed words buffered in the output FIFO (power of two, at least 2).
REQ-003 SHALL provide port: clk  input  1  single clock; all logic updates on the rising edge.
REQ-004 SHALL provide port: reset_n  input  1  reset; synchronous, active-low.
REQ-005 SHALL provide port: serial_in  input  1  serial data bit, MSB first.
REQ-006 SHALL provide port: serial_valid  input  1  bit strobe; serial_in is sampled only on edges where this is 1.
REQ-007 SHALL provide port: frame_start  input  1  qualified by serial_valid; marks the current bit as the MSB of a new word.
REQ-008 SHALL provide port: parallel_out  output  WIDTH  word at the FIFO head.
REQ-009 SHALL provide port: out_valid  output  1  FIFO is non-empty.
REQ-010 SHALL provide port: out_ready  input  1  consumer accept; a pop occurs on edges where out_valid and out_ready are both 1.
REQ-011 SHALL provide port: overrun  output  1  sticky flag; set when a completed word is dropped.
REQ-012 SHALL provide port: frame_err  output  1  one-cycle pulse; a partial word was aborted by frame_start.

Function
REQ-013 SHALL implement a two-state FSM with states IDLE and SHIFT.
REQ-014 IDLE: serial_valid=1 with frame_start=0 SHALL be ignored.
REQ-015 IDLE: serial_valid=1 with frame_start=1 SHALL do all of the following: load serial_in as the MSB, set the bit count to 1, move to SHIFT.
REQ-016 SHIFT: each serial_valid=1 with frame_start=0 SHALL shift serial_in in at the LSB (left shift) and increment the bit count.
REQ-017 SHIFT: edges with serial_valid=0 SHALL leave the shifter and the count unchanged; arbitrary gaps between bits are allowed.
REQ-018 On the edge that samples bit number WIDTH, the assembled word SHALL be pushed into the FIFO and the FSM SHALL return to IDLE.
REQ-019 The pushed word SHALL be {previous WIDTH-1 bits, current serial_in}.
REQ-020 SHIFT: serial_valid=1 with frame_start=1 SHALL discard the partial word, pulse frame_err on the next cycle, and restart with this bit as MSB (count=1, remain in SHIFT).
REQ-021 frame_start=1 on the bit that would otherwise complete a word SHALL be treated as a resync per REQ-020; no push occurs.
REQ-022 Latency: with an empty FIFO, out_valid SHALL be 1 and parallel_out SHALL hold the word in the cycle after the edge that samples the last bit.
REQ-023 parallel_out SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 FIFO order SHALL be first-in first-out.
REQ-025 Push when the FIFO is full and no pop occurs that edge: the word SHALL be dropped, FIFO contents SHALL be unchanged, and overrun SHALL be set to 1.
REQ-026 Push and pop on the same edge when full: both SHALL take effect and the occupancy SHALL remain DEPTH.
REQ-027 Push and pop on the same edge when occupancy is 1: the new word SHALL become the head the next cycle and out_valid SHALL stay 1.
REQ-028 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-029 The occupancy counter SHALL be log2(DEPTH)+1 bits wide.
REQ-030 overrun SHALL clear only on reset.

Reset
REQ-031 With reset_n=0 at a rising edge, the design SHALL do all of the following: FSM to IDLE, bit count=0, shifter=0, FIFO emptied, parallel_out=0, out_valid=0, overrun=0, frame_err=0.
REQ-032 Reset SHALL take priority over all other inputs.
REQ-033 A word in progress when reset is asserted SHALL be lost and SHALL NOT be pushed.
REQ-034 After reset, the first serial_valid bit without frame_start SHALL be ignored.

Verification
REQ-035 Basic: frame_start on bit 1, bits 1,0,1,0,0,1,0,1 on consecutive cycles, out_ready=1 -> out_valid high for one cycle with parallel_out=0xA5; overrun=0.
REQ-036 Gapped: the same 0xA5 bits with 3 idle cycles between each -> a single word 0xA5; no word is emitted before the 8th bit.
REQ-037 Backpressure: out_ready=0, words 0x11, 0x22, 0x33 sent -> out_valid=1 and overrun=1; raising out_ready pops 0x11 then 0x22; 0x33 never appears.
REQ-038 Resync: frame_start, 3 bits of 0xFF, then frame_start with bits of 0x3C -> frame_err pulses once; the only word output is 0x3C.
REQ-039 Reset mid-word: reset_n=0 after 5 bits, then a full 0x5A frame -> the only word output is 0x5A; overrun=0.
REQ-040 Full plus simultaneous pop: FIFO holds 0x01 and 0x02, the last bit of 0x03 arrives on an edge with out_ready=1 -> 0x01 popped, FIFO holds 0x02 then 0x03, overrun stays 0.

Source files
------------

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: MSB-first framed bit stream assembled into
// WIDTH-bit words and buffered in a small FIFO with a valid/ready output.
module sipo_rx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             serial_in,
    input  logic             serial_valid,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int SH_W  = WIDTH - 1;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    // Only the first WIDTH-1 bits need holding; the last bit goes straight
    // from serial_in into the pushed word.
    logic [SH_W-1:0]  r_shift;
    logic [SH_W-1:0]  w_shift_nxt;
    logic [WIDTH-1:0] w_push_word;
    logic             w_push;
    logic             w_abort;
    logic             r_frame_err;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_shift     <= w_shift_nxt;
            r_frame_err <= w_abort;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push        = 1'b0;
        w_abort       = 1'b0;
        w_push_word   = {r_shift, serial_in};
        case (r_state)
            IDLE: begin
                if (serial_valid && frame_start) begin
                    w_shift_nxt   = SH_W'(serial_in);
                    w_bit_cnt_nxt = CNT_W'(1);
                    w_state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (serial_valid) begin
                    if (frame_start) begin
                        // Resync wins even over the bit that would complete a word.
                        w_abort       = 1'b1;
                        w_shift_nxt   = SH_W'(serial_in);
                        w_bit_cnt_nxt = CNT_W'(1);
                    end else if (r_bit_cnt == LAST_CNT) begin
                        w_push        = 1'b1;
                        w_shift_nxt   = '0;
                        w_bit_cnt_nxt = '0;
                        w_state_nxt   = IDLE;
                    end else begin
                        w_shift_nxt   = w_push_word[SH_W-1:0];
                        w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Output handshake: a word transfers on any rising edge where out_valid
    // and out_ready are both 1; parallel_out is held while out_ready is 0.
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    logic             r_overrun;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_wr_en;
    logic             w_drop;

    assign w_empty = (r_occ == '0);
    assign w_full  = (r_occ == FULL_OCC);
    assign w_pop   = !w_empty && out_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_wr_en = w_push && (!w_full || w_pop);
    assign w_drop  = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_occ     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_word;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign parallel_out = r_mem[r_rd_ptr];
    assign out_valid    = !w_empty;
    assign overrun      = r_overrun;
    assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: linear stimulus steps, immediate-assertion
// checks and a queue of expected output words.
module tb_sipo_rx;

    logic       clk;
    logic       reset_n;
    logic       serial_in;
    logic       serial_valid;
    logic       frame_start;
    logic [7:0] parallel_out;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       frame_err;

    int n_checks = 0;
    int n_errors = 0;
    int err_pulses = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    sipo_rx #(.WIDTH(8), .DEPTH(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .frame_start  (frame_start),
        .parallel_out (parallel_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so negedge sees what the next edge uses.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
            got_q.push_back(parallel_out);
        if (frame_err === 1'b1)
            err_pulses++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b, input logic fs);
        serial_valid = 1'b1;
        serial_in    = b;
        frame_start  = fs;
        tick();
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        serial_in    = 1'b0;
    endtask

    // Sends the top nbits of w, MSB first, frame_start on the MSB.
    task automatic send_word(input logic [7:0] w, input int nbits, input int gap);
        for (int i = 7; i > 7 - nbits; i--) begin
            bit_in(w[i], i == 7);
            if (i > 0) repeat (gap) tick();
        end
    endtask

    task automatic check_words(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size())
                chk(tag, {24'h0, got_q[i]}, {24'h0, exp_q[i]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] w;
        reset_n      = 1'b0;
        serial_in    = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        out_ready    = 1'b0;
        tick();
        // Reset beats a simultaneous start bit.
        serial_valid = 1'b1;
        frame_start  = 1'b1;
        serial_in    = 1'b1;
        out_ready    = 1'b1;
        tick();
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        serial_in    = 1'b0;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_parallel_out", parallel_out, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_frame_err", frame_err, 0);
        reset_n = 1'b1;

        // Basic 0xA5, preceded by a stray unframed bit that must be ignored.
        bit_in(1'b1, 1'b0);
        send_word(8'hA5, 7, 0);
        chk("basic_early", out_valid, 0);
        bit_in(1'b1, 1'b0);
        chk("basic_valid", out_valid, 1);
        chk("basic_data", parallel_out, 8'hA5);
        tick();
        chk("basic_one_cycle", out_valid, 0);
        chk("basic_overrun", overrun, 0);
        exp_q.push_back(8'hA5);
        check_words("basic_words");

        // Gapped bits.
        send_word(8'hA5, 7, 3);
        repeat (3) tick();
        chk("gap_early", out_valid, 0);
        bit_in(1'b1, 1'b0);
        chk("gap_valid", out_valid, 1);
        chk("gap_data", parallel_out, 8'hA5);
        tick();
        exp_q.push_back(8'hA5);
        check_words("gap_words");

        // Backpressure: third word dropped.
        out_ready = 1'b0;
        send_word(8'h11, 8, 0);
        send_word(8'h22, 8, 0);
        send_word(8'h33, 8, 0);
        chk("bp_valid", out_valid, 1);
        chk("bp_overrun", overrun, 1);
        chk("bp_head", parallel_out, 8'h11);
        repeat (3) tick();
        chk("bp_stable", parallel_out, 8'h11);
        out_ready = 1'b1;
        tick();
        chk("bp_head2", parallel_out, 8'h22);
        tick();
        chk("bp_drained", out_valid, 0);
        tick();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        check_words("bp_words");

        // Resync after 3 bits.
        err_pulses = 0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b1, 1'b0);
        bit_in(1'b1, 1'b0);
        w = 8'h3C;
        bit_in(w[7], 1'b1);
        chk("resync_err_pulse", frame_err, 1);
        bit_in(w[6], 1'b0);
        chk("resync_err_clear", frame_err, 0);
        for (int i = 5; i >= 0; i--) bit_in(w[i], 1'b0);
        chk("resync_data", parallel_out, 8'h3C);
        tick();
        chk("resync_err_count", err_pulses, 1);
        exp_q.push_back(8'h3C);
        check_words("resync_words");

        // frame_start on what would have been the completing bit.
        err_pulses = 0;
        send_word(8'h77, 7, 0);
        send_word(8'h81, 8, 0);
        tick();
        chk("resync8_err_count", err_pulses, 1);
        exp_q.push_back(8'h81);
        check_words("resync8_words");

        // Reset mid-word; overrun is still sticky from backpressure.
        send_word(8'hFF, 5, 0);
        chk("sticky_overrun", overrun, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("midrst_overrun", overrun, 0);
        chk("midrst_valid", out_valid, 0);
        send_word(8'h5A, 8, 0);
        tick();
        chk("midrst_overrun2", overrun, 0);
        exp_q.push_back(8'h5A);
        check_words("midrst_words");

        // Full FIFO with simultaneous pop on the completing bit.
        out_ready = 1'b0;
        send_word(8'h01, 8, 0);
        send_word(8'h02, 8, 0);
        chk("full_head", parallel_out, 8'h01);
        w = 8'h03;
        send_word(w, 7, 0);
        out_ready = 1'b1;
        bit_in(w[0], 1'b0);
        out_ready = 1'b0;
        chk("full_pp_valid", out_valid, 1);
        chk("full_pp_head", parallel_out, 8'h02);
        chk("full_pp_overrun", overrun, 0);
        out_ready = 1'b1;
        tick();
        chk("full_pp_head3", parallel_out, 8'h03);
        tick();
        chk("full_pp_drained", out_valid, 0);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h03);
        check_words("full_pp_words");

        // Push and pop together at occupancy 1.
        out_ready = 1'b0;
        send_word(8'h44, 8, 0);
        chk("one_head", parallel_out, 8'h44);
        w = 8'h55;
        send_word(w, 7, 0);
        out_ready = 1'b1;
        bit_in(w[0], 1'b0);
        out_ready = 1'b0;
        chk("one_pp_valid", out_valid, 1);
        chk("one_pp_head", parallel_out, 8'h55);
        out_ready = 1'b1;
        tick();
        chk("one_pp_drained", out_valid, 0);
        chk("one_pp_overrun", overrun, 0);
        exp_q.push_back(8'h44);
        exp_q.push_back(8'h55);
        check_words("one_pp_words");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
